// File: rtl/ans_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ans_pkg
// Description : Shared widths, typedefs and controller state encoding for the
//               ANS frequency-table block.
// Revision    : 1.0 - initial release
// ============================================================================
package ans_pkg;

    localparam int SYM_WIDTH = 4;
    localparam int SYM_COUNT = 16;
    localparam int CNT_WIDTH = 4;
    // 16 symbols of at most 15 each cannot exceed 8 bits.
    localparam int CUM_WIDTH = CNT_WIDTH + SYM_WIDTH;

    typedef logic [SYM_WIDTH-1:0] sym_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;
    typedef logic [CUM_WIDTH-1:0] cum_t;

    localparam sym_t SYM_LAST = sym_t'(SYM_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PREFIX = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ans_cum_table.sv
`default_nettype none
// ============================================================================
// Module      : ans_cum_table
// Description : Per-symbol count and inclusive cumulative register arrays with
//               a count write port, a serial prefix-sum engine and a
//               combinational symbol lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module ans_cum_table
    import ans_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic wr_en,
    input  sym_t wr_idx,
    input  cnt_t wr_data,
    input  logic start,
    output logic pfx_last,
    output cum_t pfx_sum,
    input  sym_t rd_sym,
    output cnt_t rd_count,
    output cum_t rd_cum,
    output cum_t total
);

    cnt_t r_cnt [SYM_COUNT];
    cum_t r_cum [SYM_COUNT];
    logic r_run;
    sym_t r_idx;
    cum_t r_acc;

    cum_t w_sum;
    sym_t w_prev;

    assign w_sum    = r_acc + cum_t'(r_cnt[r_idx]);
    assign pfx_last = r_run && (r_idx == SYM_LAST);
    assign pfx_sum  = w_sum;

    // Lookup: cumulative is exclusive of the symbol itself.
    assign w_prev   = rd_sym - sym_t'(1);
    assign rd_count = r_cnt[rd_sym];
    assign rd_cum   = (rd_sym == '0) ? '0 : r_cum[w_prev];
    assign total    = r_cum[SYM_LAST];

    // Count array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ena && wr_en) begin
            r_cnt[wr_idx] <= wr_data;
        end
    end

    // Inclusive cumulative array, one entry per engine cycle.
    always_ff @(posedge clk) begin
        if (ena && r_run && !start) begin
            r_cum[r_idx] <= w_sum;
        end
    end

    // Prefix engine sequencing: SYM_COUNT cycles from start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_idx <= '0;
            r_acc <= '0;
        end else if (ena) begin
            if (start) begin
                r_run <= 1'b1;
                r_idx <= '0;
                r_acc <= '0;
            end else if (r_run) begin
                r_acc <= w_sum;
                r_idx <= r_idx + sym_t'(1);
                if (r_idx == SYM_LAST) begin
                    r_run <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ans_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ans_table_ctrl
// Description : Loads symbol counts, builds the cumulative table and feeds
//               per-symbol {count, cumulative, total} words to ans_encoder
//               through a one-entry handshaked pipe register.
// Revision    : 1.0 - initial release
// ============================================================================
module ans_table_ctrl
    import ans_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 load_start,
    input  logic [CNT_WIDTH-1:0] cnt_data,
    input  logic                 cnt_vld,
    output logic                 cnt_rdy,
    input  logic [SYM_WIDTH-1:0] sym_in,
    input  logic                 sym_vld,
    output logic                 sym_rdy,
    output logic [CNT_WIDTH-1:0] enc_s_count,
    output logic [CUM_WIDTH-1:0] enc_s_cumulative,
    output logic [CUM_WIDTH-1:0] enc_total_count,
    output logic                 enc_in_vld,
    input  logic                 enc_in_rdy,
    output logic                 tbl_valid,
    output logic                 busy,
    output logic                 err_zero_sym,
    output logic                 err_empty_table
);

    state_t r_state;
    sym_t   r_idx;
    logic   r_pending;
    logic   r_pipe_full;
    cnt_t   r_enc_count;
    cum_t   r_enc_cum;
    cum_t   r_enc_total;
    logic   r_tbl_valid;
    logic   r_busy;
    logic   r_err_zero;
    logic   r_err_empty;

    logic w_cnt_acc;
    logic w_sym_acc;
    logic w_take;
    logic w_pfx_start;
    logic w_pfx_last;
    cum_t w_pfx_sum;
    cnt_t w_rd_count;
    cum_t w_rd_cum;
    cum_t w_total;

    assign cnt_rdy     = ena && (r_state == ST_LOAD);
    assign sym_rdy     = ena && (r_state == ST_RUN) && !r_pending
                         && (!r_pipe_full || enc_in_rdy);
    assign w_cnt_acc   = cnt_vld && cnt_rdy;
    assign w_sym_acc   = sym_vld && sym_rdy;
    assign w_take      = ena && r_pipe_full && enc_in_rdy;
    assign w_pfx_start = w_cnt_acc && (r_idx == SYM_LAST);

    ans_cum_table u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .wr_en    (w_cnt_acc),
        .wr_idx   (r_idx),
        .wr_data  (cnt_data),
        .start    (w_pfx_start),
        .pfx_last (w_pfx_last),
        .pfx_sum  (w_pfx_sum),
        .rd_sym   (sym_in),
        .rd_count (w_rd_count),
        .rd_cum   (w_rd_cum),
        .total    (w_total)
    );

    assign enc_s_count      = r_enc_count;
    assign enc_s_cumulative = r_enc_cum;
    assign enc_total_count  = r_enc_total;
    assign enc_in_vld       = r_pipe_full;
    assign tbl_valid        = r_tbl_valid;
    assign busy             = r_busy;
    assign err_zero_sym     = r_err_zero;
    assign err_empty_table  = r_err_empty;

    // Control FSM, pipe register and status/pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_pending   <= 1'b0;
            r_pipe_full <= 1'b0;
            r_enc_count <= '0;
            r_enc_cum   <= '0;
            r_enc_total <= '0;
            r_tbl_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err_zero  <= 1'b0;
            r_err_empty <= 1'b0;
        end else if (ena) begin
            r_err_zero  <= 1'b0;
            r_err_empty <= 1'b0;
            // A same-cycle accept below overrides this drain.
            if (w_take) begin
                r_pipe_full <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_cnt_acc) begin
                        r_idx <= r_idx + sym_t'(1);
                        if (r_idx == SYM_LAST) begin
                            r_state <= ST_PREFIX;
                        end
                    end
                end
                ST_PREFIX: begin
                    if (w_pfx_last) begin
                        r_busy <= 1'b0;
                        if (w_pfx_sum == '0) begin
                            r_err_empty <= 1'b1;
                            r_tbl_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_tbl_valid <= 1'b1;
                            r_state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        r_pending <= 1'b1;
                    end
                    if (w_sym_acc) begin
                        if (w_rd_count != '0) begin
                            r_pipe_full <= 1'b1;
                            r_enc_count <= w_rd_count;
                            r_enc_cum   <= w_rd_cum;
                            r_enc_total <= w_total;
                        end else begin
                            r_err_zero <= 1'b1;
                        end
                    end
                    // Reload only once the encoder has drained the pipe.
                    if (r_pending && !r_pipe_full) begin
                        r_tbl_valid <= 1'b0;
                        r_pending   <= 1'b0;
                        r_state     <= ST_LOAD;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ans_table_ctrl.md
Name: ans_table_ctrl

Overview:
- Owns the symbol frequency table for ans_encoder and sequences symbols into it.
- Loads per-symbol counts from a host stream and builds the inclusive cumulative table serially, one entry per cycle.
- In RUN mode, accepts host symbols and looks up count, cumulative and total for each one.
- Presents each symbol's lookup to the encoder as a registered, handshaked word. Sits between the host interface and ans_encoder.

Parameters:
- SYM_WIDTH, 4, symbol index width.
- SYM_COUNT, 16, number of symbols; must equal 2**SYM_WIDTH.
- CNT_WIDTH, 4, per-symbol count width.
- CUM_WIDTH, CNT_WIDTH+SYM_WIDTH, cumulative/total width; cannot overflow by construction.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  design enable; when low all state holds and no handshake completes.
- load_start  in  1  single-cycle request to reload the table.
- cnt_data  in  CNT_WIDTH  count for the next symbol, sent in symbol order 0..SYM_COUNT-1.
- cnt_vld  in  1  cnt_data valid.
- cnt_rdy  out  1  count accepted when cnt_vld & cnt_rdy.
- sym_in  in  SYM_WIDTH  symbol from host.
- sym_vld  in  1  sym_in valid.
- sym_rdy  out  1  symbol accepted when sym_vld & sym_rdy.
- enc_s_count  out  CNT_WIDTH  count of held symbol.
- enc_s_cumulative  out  CUM_WIDTH  0 for symbol 0, else cum[sym-1].
- enc_total_count  out  CUM_WIDTH  cum[SYM_COUNT-1].
- enc_in_vld  out  1  word valid to encoder (drives encoder in_vld).
- enc_in_rdy  in  1  encoder in_rdy.
- tbl_valid  out  1  table built and non-empty.
- busy  out  1  state is LOAD or PREFIX.
- err_zero_sym  out  1  one-cycle pulse: accepted symbol had count 0 and was dropped.
- err_empty_table  out  1  one-cycle pulse: loaded table summed to 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; all outputs 0; pipe register empty; load_pending=0.
  - cnt/cum arrays are not cleared.
  - Reset mid-LOAD or mid-PREFIX abandons the load; tbl_valid=0.
- FSM states: IDLE, LOAD, PREFIX, RUN.
- IDLE:
  - cnt_rdy=0, sym_rdy=0.
  - load_start -> LOAD, load index idx=0.
- LOAD:
  - cnt_rdy=1.
  - Each accepted count writes cnt[idx] and increments idx.
  - Accepting at idx=SYM_COUNT-1 -> PREFIX with idx=0, acc=0.
  - load_start is ignored while in LOAD.
- PREFIX:
  - Per cycle: acc+=cnt[idx]; cum[idx]=acc (inclusive); idx++.
  - Lasts exactly SYM_COUNT cycles.
  - At exit, if total==0: pulse err_empty_table, tbl_valid=0, go to IDLE.
  - Otherwise tbl_valid=1, go to RUN.
- RUN:
  - One-entry pipe register holds {count, cumulative}. enc_in_vld = pipe_full.
  - sym_rdy = !load_pending & (!pipe_full | enc_in_rdy).
  - On accept: lookup is combinational from the table; pipe loads on the same edge; enc_in_vld rises the next cycle (latency 1).
  - If the encoder takes the word and a new symbol is accepted in the same cycle, the pipe reloads with no bubble. Full throughput is 1 symbol/cycle.
  - If the looked-up count is 0: symbol is consumed, pipe not loaded, err_zero_sym pulses on the cycle after acceptance.
  - Pipe outputs are held stable while enc_in_vld & !enc_in_rdy.
- load_start in RUN:
  - Sets load_pending, which forces sym_rdy=0.
  - When the pipe is empty: tbl_valid=0, clear load_pending, go to LOAD.
  - load_start while load_pending is already set has no additional effect.
- ena low: freezes state, pipe, pulses and handshakes. cnt_rdy=0, sym_rdy=0, enc_in_vld held.
- Outputs are registered except cnt_rdy and sym_rdy, which are combinational from state, pipe and ena.

Decomposition:
- Package ans_pkg holds:
  - SYM_WIDTH, SYM_COUNT, CNT_WIDTH, CUM_WIDTH constants;
  - sym_t, cnt_t, cum_t typedefs;
  - the state enum.
- Sub-module ans_cum_table holds the cnt/cum register arrays, the write port and the serial prefix-sum engine (start, done, total). The FSM and pipe stay in ans_table_ctrl.

Test Plan:
- Reset -> all outputs 0, sym_rdy=0, cnt_rdy=0 while IDLE.
- Load sequence:
  - Stimulus: load_start, then counts {3,5,0,8,0x12}.
  - Response: busy for 16 accepts plus 16 PREFIX cycles; then tbl_valid=1 and enc_total_count=16 once a symbol is sent.
- Lookup with the loaded table:
  - Send sym 3 -> next cycle enc_in_vld=1, enc_s_count=8, enc_s_cumulative=8, enc_total_count=16.
  - Send sym 0 -> enc_s_count=3, enc_s_cumulative=0.
- Zero-count symbol:
  - Send sym 2 -> sym accepted, enc_in_vld stays 0, err_zero_sym=1 for exactly one cycle.
- Backpressure:
  - Hold enc_in_rdy=0, send sym 1 then sym 0 -> sym_rdy=0 after the first accept; enc_s_count=5 and enc_s_cumulative=3 held.
  - Release -> sym 1 word, then sym 0 word (count 3, cum 0), in order, none lost.
- Empty table and reset mid-load:
  - Load all zeros -> err_empty_table pulse, tbl_valid=0, state IDLE.
  - Separately, rst_n low after 5 counts -> next cycle busy=0, tbl_valid=0, cnt_rdy=0.
